// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, ALU ops, mux selects,
// jump conditions, FSM states and status-flag bit positions.
package ctrl_pkg;

  localparam logic [6:0] OP_NOP       = 7'b0000000;
  localparam logic [6:0] OP_MOV_A_LIT = 7'b0000010;
  localparam logic [6:0] OP_MOV_B_LIT = 7'b0000011;
  localparam logic [6:0] OP_SUB_A_LIT = 7'b0001010;
  localparam logic [6:0] OP_CMP_AB    = 7'b1001101;
  localparam logic [6:0] OP_ST_DIR    = 7'b0100111;
  localparam logic [6:0] OP_LD_DIR    = 7'b0100101;
  localparam logic [6:0] OP_JMP       = 7'b1010011;
  localparam logic [6:0] OP_JEQ       = 7'b1010100;
  localparam logic [6:0] OP_JNE       = 7'b1010101;
  localparam logic [6:0] OP_JGT       = 7'b1010110;
  localparam logic [6:0] OP_JLT       = 7'b1010111;

  localparam logic [3:0] ALU_PASS_B = 4'b1001;
  localparam logic [3:0] ALU_SUB    = 4'b0001;
  localparam logic [3:0] ALU_CMP    = 4'b1111;

  localparam logic [1:0] MUXB_REGB = 2'b00;
  localparam logic [1:0] MUXB_LIT  = 2'b01;
  localparam logic [1:0] MUXB_MEM  = 2'b10;

  // Jump condition codes equal the low three opcode bits of the jump family.
  localparam logic [2:0] JC_ALWAYS = 3'd3;
  localparam logic [2:0] JC_EQ     = 3'd4;
  localparam logic [2:0] JC_NE     = 3'd5;
  localparam logic [2:0] JC_GT     = 3'd6;
  localparam logic [2:0] JC_LT     = 3'd7;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int CNT_W = 3;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_EXEC    = 3'd1,
    ST_MEMWAIT = 3'd2,
    ST_MEMWB   = 3'd3,
    ST_TRAP    = 3'd4
  } state_e;

  function automatic logic is_jump(input logic [6:0] opc);
    return (opc[6:3] == 4'b1010) && (opc[2:0] >= JC_ALWAYS);
  endfunction

  function automatic logic is_legal(input logic [6:0] opc);
    return is_jump(opc) || (opc == OP_NOP) || (opc == OP_MOV_A_LIT) ||
           (opc == OP_MOV_B_LIT) || (opc == OP_SUB_A_LIT) || (opc == OP_CMP_AB) ||
           (opc == OP_ST_DIR) || (opc == OP_LD_DIR);
  endfunction

endpackage

// File: rtl/jump_cond_eval.sv
// Combinational jump resolution: condition code plus {Z,N,C,V} flags -> taken.
module jump_cond_eval
  import ctrl_pkg::*;
(
  input  logic [2:0] jcond,
  input  logic [3:0] flags_in,
  output logic       taken
);

  logic z, n;
  logic unused_cv;

  assign z = flags_in[FLAG_Z];
  assign n = flags_in[FLAG_N];
  assign unused_cv = ^{flags_in[FLAG_C], flags_in[FLAG_V]};

  always_comb begin
    taken = 1'b0;
    case (jcond)
      JC_ALWAYS: taken = 1'b1;
      JC_EQ:     taken = z;
      JC_NE:     taken = ~z;
      JC_GT:     taken = ~z & ~n;
      JC_LT:     taken = n;
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle instruction sequencer: FETCH/EXEC/MEMWAIT/MEMWB(/TRAP) with controls decoded
// from registered state and opcode. Define CTRL_TRAP_EN to trap unknown opcodes.
//
// state      | meaning
// FETCH      | instr_ready=1, capture opcode on instr_valid
// EXEC       | one-cycle execute of the captured opcode; jumps resolve against flags_in
// MEMWAIT    | data-memory read in flight, addr_sel held, counter runs down
// MEMWB      | write memory data into register A and retire
// TRAP       | unknown opcode trapped, illegal held until reset
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter int OPC_W   = 7,
  parameter int ALU_W   = 4,
  parameter int MEM_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [OPC_W-1:0] opcode,
  input  logic [3:0]       flags_in,
  output logic [ALU_W-1:0] alu_op,
  output logic             muxA_sel,
  output logic [1:0]       muxB_sel,
  output logic             regA_load,
  output logic             regB_load,
  output logic             mem_write,
  output logic             addr_sel,
  output logic             flags_write,
  output logic             pc_load,
  output logic             pc_inc,
  output logic             illegal
);

  state_e           state_q, state_d;
  logic [OPC_W-1:0] opcode_q;
  logic [CNT_W-1:0] cnt_q;
  logic             jump_taken;

  jump_cond_eval u_jump_cond_eval (
    .jcond    (opcode_q[2:0]),
    .flags_in (flags_in),
    .taken    (jump_taken)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_FETCH;
      opcode_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_FETCH && instr_valid)
        opcode_q <= opcode;
      if (state_q == ST_EXEC)
        cnt_q <= CNT_W'(MEM_LAT - 1);
      else if (state_q == ST_MEMWAIT)
        cnt_q <= cnt_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:   if (instr_valid) state_d = ST_EXEC;
      ST_EXEC: begin
        if (opcode_q == OP_LD_DIR)
          state_d = (MEM_LAT == 1) ? ST_MEMWB : ST_MEMWAIT;
`ifdef CTRL_TRAP_EN
        else if (!is_legal(opcode_q))
          state_d = ST_TRAP;
`endif
        else
          state_d = ST_FETCH;
      end
      // Counter is loaded with MEM_LAT-1, so leaving on the 1->0 step gives MEM_LAT-1 wait cycles.
      ST_MEMWAIT: if (cnt_q == CNT_W'(1)) state_d = ST_MEMWB;
      ST_MEMWB:   state_d = ST_FETCH;
      ST_TRAP:    state_d = ST_TRAP;
      default:    state_d = ST_FETCH;
    endcase
  end

  // Controls come from registered state/opcode only; reset forces them low so an aborted
  // instruction never retires.
  always_comb begin
    instr_ready = 1'b0;
    alu_op      = '0;
    muxA_sel    = 1'b0;
    muxB_sel    = MUXB_REGB;
    regA_load   = 1'b0;
    regB_load   = 1'b0;
    mem_write   = 1'b0;
    addr_sel    = 1'b0;
    flags_write = 1'b0;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;
    illegal     = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_FETCH: instr_ready = 1'b1;
        ST_EXEC: begin
          case (opcode_q)
            OP_MOV_A_LIT: begin
              alu_op = ALU_W'(ALU_PASS_B); muxB_sel = MUXB_LIT; regA_load = 1'b1; pc_inc = 1'b1;
            end
            OP_MOV_B_LIT: begin
              alu_op = ALU_W'(ALU_PASS_B); muxB_sel = MUXB_LIT; regB_load = 1'b1; pc_inc = 1'b1;
            end
            OP_SUB_A_LIT: begin
              alu_op = ALU_W'(ALU_SUB); muxB_sel = MUXB_LIT; regA_load = 1'b1; pc_inc = 1'b1;
            end
            OP_CMP_AB: begin
              alu_op = ALU_W'(ALU_CMP); muxB_sel = MUXB_REGB; flags_write = 1'b1; pc_inc = 1'b1;
            end
            OP_ST_DIR: begin
              addr_sel = 1'b1; mem_write = 1'b1; pc_inc = 1'b1;
            end
            OP_LD_DIR: addr_sel = 1'b1;
            OP_JMP, OP_JEQ, OP_JNE, OP_JGT, OP_JLT: begin
              pc_load = jump_taken;
              pc_inc  = ~jump_taken;
            end
            OP_NOP: pc_inc = 1'b1;
            default: begin
`ifdef CTRL_TRAP_EN
              pc_inc = 1'b0;
`else
              pc_inc = 1'b1;
`endif
            end
          endcase
        end
        ST_MEMWAIT: addr_sel = 1'b1;
        ST_MEMWB: begin
          addr_sel  = 1'b1;
          muxB_sel  = MUXB_MEM;
          alu_op    = ALU_W'(ALU_PASS_B);
          regA_load = 1'b1;
          pc_inc    = 1'b1;
        end
        ST_TRAP: begin
`ifdef CTRL_TRAP_EN
          illegal = 1'b1;
`endif
        end
        default: instr_ready = 1'b0;
      endcase
    end
  end

endmodule
